// File: rtl/spart_pkg.sv
// Shared constants for the SPART key-event front end: default key codes
// and a small pointer-width helper.
package spart_pkg;

    localparam logic [7:0] KEY_W = 8'h77;
    localparam logic [7:0] KEY_A = 8'h61;
    localparam logic [7:0] KEY_S = 8'h73;
    localparam logic [7:0] KEY_D = 8'h64;
    localparam logic [7:0] KEY_J = 8'h6A;

    localparam int DEFAULT_NUM_KEYS = 5;

    // Slice [8*i+:8] maps to mask bit i, so 'j' is bit 0 and 'w' is bit 4.
    localparam logic [8*DEFAULT_NUM_KEYS-1:0] DEFAULT_KEY_CODES =
        {KEY_W, KEY_A, KEY_S, KEY_D, KEY_J};

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spart_mask_fifo.sv
// Circular mask queue with an OR-into-tail operation; head and count are
// registered from the next-state image so they change one clock after a request.
module spart_mask_fifo
    import spart_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             or_tail,
    input  logic [WIDTH-1:0] or_data,   // data for both push and or_tail
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_r      [DEPTH];
    logic [WIDTH-1:0] mem_next_s [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_next_s, wr_next_s, tail_ptr_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic [WIDTH-1:0] head_r;
    logic             pop_ok_s, push_ok_s, or_ok_s;

    function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] p, input logic up);
        if (up) begin
            return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
        end else begin
            return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
        end
    endfunction

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == '0);
    assign tail_ptr_s = ptr_step(wr_ptr_r, 1'b0);
    assign pop_ok_s   = pop & ~empty;
    assign push_ok_s  = push & (~full | pop_ok_s);
    assign or_ok_s    = or_tail & ~empty;

    // Next-state image of storage, pointers and occupancy.
    always_comb begin
        mem_next_s   = mem_r;
        rd_next_s    = rd_ptr_r;
        wr_next_s    = wr_ptr_r;
        count_next_s = count_r;
        if (or_ok_s) begin
            mem_next_s[tail_ptr_s] = mem_r[tail_ptr_s] | or_data;
        end else begin
            mem_next_s[tail_ptr_s] = mem_r[tail_ptr_s];
        end
        if (push_ok_s) begin
            mem_next_s[wr_ptr_r] = or_data;
            wr_next_s            = ptr_step(wr_ptr_r, 1'b1);
        end else begin
            wr_next_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_next_s = ptr_step(rd_ptr_r, 1'b1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
    end

    // Queue state and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
        end else begin
            mem_r    <= mem_next_s;
            rd_ptr_r <= rd_next_s;
            wr_ptr_r <= wr_next_s;
            count_r  <= count_next_s;
            head_r   <= (count_next_s == '0) ? '0 : mem_next_s[rd_next_s];
        end
    end

    assign head  = head_r;
    assign tail  = mem_r[tail_ptr_s];
    assign count = count_r;

endmodule

// File: rtl/spart_key_event_queue.sv
// Key-event front end: detects new SPART bytes, matches them against the key
// table and queues (optionally coalesced) key masks for the CPU.
module spart_key_event_queue
    import spart_pkg::*;
#(
    parameter int                    NUM_KEYS   = 5,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES  = DEFAULT_KEY_CODES,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    COALESCE   = 1,
    parameter int                    CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rda,
    input  logic [7:0]          databus,
    input  logic                cpu_read,
    input  logic                clear_overflow,
    output logic [NUM_KEYS-1:0] bit_mask,
    output logic                bit_mask_ready,
    output logic                overflow,
    output logic [CNT_W-1:0]    fifo_count
);

    logic                rda_q_r, overflow_r;
    logic                rda_edge_s, event_s, pop_s, target_valid_s;
    logic                push_s, or_tail_s, drop_s;
    logic [NUM_KEYS-1:0] match_s, head_s, tail_s;
    logic [CNT_W-1:0]    count_s;
    logic                full_s, empty_s;

    // Key table compare; duplicate codes light several bits.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_s[i] = (databus == KEY_CODES[8*i +: 8]);
        end
    end

    assign rda_edge_s     = rda & ~rda_q_r;
    assign event_s        = rda_edge_s & (match_s != '0);
    assign pop_s          = cpu_read & ~empty_s;
    assign target_valid_s = (count_s > CNT_W'(1)) | ((count_s == CNT_W'(1)) & ~pop_s);

    // Event resolution: coalesce into tail, else push, else drop.
    always_comb begin
        push_s    = 1'b0;
        or_tail_s = 1'b0;
        drop_s    = 1'b0;
        if (event_s) begin
            if ((COALESCE != 0) && target_valid_s && ((tail_s & match_s) == '0)) begin
                or_tail_s = 1'b1;
            end else if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // rda edge history and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rda_q_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            rda_q_r <= rda;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    spart_mask_fifo #(
        .WIDTH (NUM_KEYS),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .or_tail (or_tail_s),
        .or_data (match_s),
        .head    (head_s),
        .tail    (tail_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign bit_mask       = head_s;
    assign bit_mask_ready = ~empty_s;
    assign overflow       = overflow_r;
    assign fifo_count     = count_s;

endmodule

// File: tb/tb_spart_key_event_queue.sv
// Directed bench: one coalescing and one non-coalescing instance share stimulus.
module tb_spart_key_event_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rda = 1'b0;
    logic       cpu_read = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [7:0] databus = 8'h00;

    logic [4:0] mask_c, mask_n;
    logic       ready_c, ready_n, ovf_c, ovf_n;
    logic [2:0] cnt_c, cnt_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spart_key_event_queue #(.COALESCE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rda(rda), .databus(databus), .cpu_read(cpu_read),
        .clear_overflow(clear_overflow), .bit_mask(mask_c), .bit_mask_ready(ready_c),
        .overflow(ovf_c), .fifo_count(cnt_c)
    );

    spart_key_event_queue #(.COALESCE(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rda(rda), .databus(databus), .cpu_read(cpu_read),
        .clear_overflow(clear_overflow), .bit_mask(mask_n), .bit_mask_ready(ready_n),
        .overflow(ovf_n), .fifo_count(cnt_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic rd);
        databus  = b;
        rda      = 1'b1;
        cpu_read = rd;
        tick();
        rda      = 1'b0;
        cpu_read = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        for (int k = 0; k < n; k++) begin
            cpu_read = 1'b1;
            tick();
            cpu_read = 1'b0;
            tick();
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_mask", 32'(mask_c), 32'h0);
        check("rst_ready", 32'(ready_c), 32'h0);
        check("rst_ovf", 32'(ovf_c), 32'h0);
        check("rst_cnt", 32'(cnt_c), 32'h0);
        rst_n = 1'b1;
        tick();

        // noise byte and read while empty
        send(8'h41, 1'b0);
        check("noise_cnt_c", 32'(cnt_c), 32'h0);
        check("noise_cnt_n", 32'(cnt_n), 32'h0);
        pop_n(1);
        check("rd_empty_cnt", 32'(cnt_c), 32'h0);
        check("rd_empty_rdy", 32'(ready_c), 32'h0);

        // coalesce w + d
        send(8'h77, 1'b0);
        check("lat_ready", 32'(ready_c), 32'h1);
        send(8'h64, 1'b0);
        check("coal_mask", 32'(mask_c), 32'h12);
        check("coal_cnt", 32'(cnt_c), 32'h1);
        check("nocoal_cnt", 32'(cnt_n), 32'h2);
        check("nocoal_mask", 32'(mask_n), 32'h10);
        pop_n(1);
        check("nocoal_next", 32'(mask_n), 32'h02);
        pop_n(1);
        check("drain_cnt_n", 32'(cnt_n), 32'h0);

        // repeated key keeps separate entries
        send(8'h61, 1'b0);
        send(8'h61, 1'b0);
        check("rep_cnt", 32'(cnt_c), 32'h2);
        check("rep_mask", 32'(mask_c), 32'h08);
        pop_n(1);
        check("rep_mask2", 32'(mask_c), 32'h08);
        check("rep_cnt2", 32'(cnt_c), 32'h1);
        pop_n(1);
        check("rep_empty", 32'(mask_c), 32'h0);

        // overflow with five j presses
        for (int k = 0; k < 5; k++) send(8'h6A, 1'b0);
        check("ovf_cnt", 32'(cnt_n), 32'h4);
        check("ovf_flag", 32'(ovf_n), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("ovf_read", 32'(mask_n), 32'h01);
            pop_n(1);
        end
        check("ovf_drained", 32'(cnt_n), 32'h0);
        check("ovf_sticky", 32'(ovf_n), 32'h1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_clear", 32'(ovf_n), 32'h0);

        // pop and push at full
        for (int k = 0; k < 4; k++) send(8'h6A, 1'b0);
        send(8'h73, 1'b1);
        check("sim_cnt", 32'(cnt_n), 32'h4);
        check("sim_ovf", 32'(ovf_n), 32'h0);
        check("sim_cnt_c", 32'(cnt_c), 32'h3);
        pop_n(2);
        check("sim_tail_c", 32'(mask_c), 32'h05);
        check("sim_mid_n", 32'(mask_n), 32'h01);
        pop_n(1);
        check("sim_tail_n", 32'(mask_n), 32'h04);
        check("sim_cnt1_n", 32'(cnt_n), 32'h1);

        // pop and push at count 1
        send(8'h77, 1'b1);
        check("one_mask_n", 32'(mask_n), 32'h10);
        check("one_cnt_n", 32'(cnt_n), 32'h1);
        check("one_mask_c", 32'(mask_c), 32'h10);
        pop_n(1);

        // level held high is one event
        databus = 8'h77;
        rda     = 1'b1;
        repeat (10) tick();
        rda = 1'b0;
        tick();
        check("level_cnt", 32'(cnt_c), 32'h1);
        check("level_cnt_n", 32'(cnt_n), 32'h1);
        pop_n(1);

        // async reset mid-burst
        send(8'h6A, 1'b0);
        send(8'h61, 1'b0);
        send(8'h73, 1'b0);
        check("burst_cnt_n", 32'(cnt_n), 32'h3);
        check("burst_mask_c", 32'(mask_c), 32'h0D);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mask", 32'(mask_n), 32'h0);
        check("arst_ready", 32'(ready_n), 32'h0);
        check("arst_cnt", 32'(cnt_n), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_cnt", 32'(cnt_n), 32'h0);
        send(8'h64, 1'b0);
        check("post_rst_mask", 32'(mask_n), 32'h02);
        check("post_rst_cnt1", 32'(cnt_n), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
